// File: rtl/recip_pkg.sv
// Shared types and constants for the per-channel reciprocal scheduler.
package recip_pkg;

    localparam int          NUM_CH_DEF    = 4;
    localparam logic [31:0] NUMERATOR_DEF = 32'd32768;
    localparam int          DIV_CYCLES    = 32;
    localparam logic [31:0] DIV0_RESULT   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WRITE
    } state_t;

endpackage

// File: rtl/serial_div32.sv
// Serial restoring divider: one quotient bit per cycle, DIV_CYCLES cycles per operation.
module serial_div32
    import recip_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] rem;
    logic [31:0] dsr;
    logic [5:0]  count;
    logic        running;

    logic [31:0] rem_in;
    logic [31:0] quo_in;
    logic [31:0] dsr_in;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    // The start cycle already performs the first iteration on the fresh operands.
    always_comb begin
        rem_in  = start ? '0 : rem;
        quo_in  = start ? dividend : quotient;
        dsr_in  = start ? divisor : dsr;
        shifted = {rem_in, quo_in[31]};
        trial   = shifted - {1'b0, dsr_in};
        if (!trial[32]) begin
            rem_nx = trial[31:0];
            quo_nx = {quo_in[30:0], 1'b1};
        end else begin
            rem_nx = shifted[31:0];
            quo_nx = {quo_in[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
            count    <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= rem_nx;
                quotient <= quo_nx;
                dsr      <= divisor;
                count    <= 6'd1;
                running  <= 1'b1;
            end else if (running) begin
                rem      <= rem_nx;
                quotient <= quo_nx;
                count    <= count + 6'd1;
                if (count == 6'(DIV_CYCLES - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/recip_scheduler.sv
// Round-robin scheduler computing NUMERATOR/duration per channel on one shared serial divider.
module recip_scheduler
    import recip_pkg::*;
#(
    parameter int          NUM_CH    = NUM_CH_DEF,
    parameter logic [31:0] NUMERATOR = NUMERATOR_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH*32-1:0]  ch_duration,
    output logic [NUM_CH*32-1:0]  reciprocal,
    output logic [NUM_CH-1:0]     recip_valid,
    output logic [NUM_CH-1:0]     div0_err,
    output logic                  busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clear_mask;
    logic [31:0]       op [NUM_CH];
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   cur;
    logic [CH_W-1:0]   gnt;
    logic              found;
    logic              cur_zero;
    logic              div_start;
    logic              div_done;
    logic [31:0]       quotient;

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        gnt   = last_grant;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(last_grant) + 32'd1 + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && pending[CH_W'(idx)]) begin
                found = 1'b1;
                gnt   = CH_W'(idx);
            end
        end
    end

    // A request landing on the grant edge re-sets the bit, so it wins over the clear.
    always_comb begin
        clear_mask = '0;
        div_start  = 1'b0;
        if (state == IDLE && found) begin
            clear_mask = NUM_CH'(1) << gnt;
            div_start  = (op[gnt] != '0);
        end
    end

    serial_div32 u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (NUMERATOR),
        .divisor  (op[gnt]),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                op[i] <= '0;
            end
            reciprocal  <= '0;
            recip_valid <= '0;
            div0_err    <= '0;
            busy        <= 1'b0;
            last_grant  <= CH_W'(NUM_CH - 1);
            cur         <= '0;
            cur_zero    <= 1'b0;
        end else begin
            recip_valid <= '0;
            div0_err    <= '0;
            pending     <= (pending & ~clear_mask) | ch_req;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_req[i]) begin
                    op[i] <= ch_duration[32*i +: 32];
                end
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        cur        <= gnt;
                        last_grant <= gnt;
                        busy       <= 1'b1;
                        cur_zero   <= (op[gnt] == '0);
                        state      <= (op[gnt] == '0) ? WRITE : DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (CH_W'(i) == cur) begin
                            reciprocal[32*i +: 32] <= cur_zero ? DIV0_RESULT : quotient;
                            recip_valid[i]         <= 1'b1;
                            div0_err[i]            <= cur_zero;
                        end
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_scheduler.sv
// Scoreboard bench for recip_scheduler: transaction-level reference model plus directed and random traffic.
module tb_recip_scheduler;

    localparam int          NUM_CH    = 4;
    localparam logic [31:0] NUMERATOR = 32'd32768;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*32-1:0] ch_duration;
    logic [NUM_CH*32-1:0] reciprocal;
    logic [NUM_CH-1:0]    recip_valid;
    logic [NUM_CH-1:0]    div0_err;
    logic                 busy;

    always #5 clk = ~clk;

    recip_scheduler #(
        .NUM_CH    (NUM_CH),
        .NUMERATOR (NUMERATOR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ch_req      (ch_req),
        .ch_duration (ch_duration),
        .reciprocal  (reciprocal),
        .recip_valid (recip_valid),
        .div0_err    (div0_err),
        .busy        (busy)
    );

    typedef struct {
        int          ch;
        logic [31:0] res;
        bit          div0;
        int          w;
    } exp_t;

    typedef struct {
        int          ch;
        logic [31:0] val;
        bit          div0;
        int          at_edge;
    } obs_t;

    exp_t        exp_q[$];
    obs_t        obs_log[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    int          last_req_edge = 0;

    // Reference model: service order and completion edge derived from the scheduling rules.
    bit          m_pending [NUM_CH];
    logic [31:0] m_op [NUM_CH];
    int          m_last = NUM_CH - 1;
    int          m_next_grant = 0;
    int          m_grant_edge = 1;
    int          m_write_edge = 0;
    logic [31:0] exp_recip [NUM_CH];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        int   c;
        bit   got;
        exp_t e;
        n++;
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_pending[i] = 1'b0;
                m_op[i]      = '0;
            end
            m_last       = NUM_CH - 1;
            m_next_grant = 0;
            m_grant_edge = 1;
            m_write_edge = 0;
            exp_q.delete();
        end else begin
            if (n >= m_next_grant) begin
                got = 1'b0;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_last + k) % NUM_CH;
                    if (!got && m_pending[c]) begin
                        got          = 1'b1;
                        m_pending[c] = 1'b0;
                        m_last       = c;
                        e.ch         = c;
                        e.div0       = (m_op[c] == 0);
                        e.res        = e.div0 ? 32'hFFFF_FFFF : NUMERATOR / m_op[c];
                        e.w          = n + (e.div0 ? 1 : 33);
                        exp_q.push_back(e);
                        m_grant_edge = n;
                        m_write_edge = e.w;
                        m_next_grant = e.w + 1;
                    end
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_req[i]) begin
                    m_pending[i] = 1'b1;
                    m_op[i]      = ch_duration[32*i +: 32];
                end
            end
        end
    end

    // Monitor: compares DUT outputs shortly after each rising edge.
    always @(posedge clk) begin
        int          ch;
        exp_t        e;
        obs_t        o;
        logic [127:0] packed_exp;
        #2;
        if (!reset_n) begin
            check("reset_reciprocal", 128'(reciprocal), '0);
            check("reset_flags", 128'({recip_valid, div0_err, busy}), '0);
            for (int i = 0; i < NUM_CH; i++) exp_recip[i] = '0;
        end else begin
            if (recip_valid != '0) begin
                ch = -1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (recip_valid[i]) ch = i;
                o.ch      = ch;
                o.val     = reciprocal[32*ch +: 32];
                o.div0    = div0_err[ch];
                o.at_edge = n;
                obs_log.push_back(o);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 128'(recip_valid), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_channel", 128'(recip_valid), 128'(NUM_CH'(1) << e.ch));
                    check("div0_flag", 128'(div0_err), e.div0 ? 128'(NUM_CH'(1) << e.ch) : '0);
                    check("result", 128'(reciprocal[32*e.ch +: 32]), 128'(e.res));
                    check("write_edge", 128'(n), 128'(e.w));
                    exp_recip[e.ch] = e.res;
                end
            end else begin
                check("div0_without_valid", 128'(div0_err), '0);
                if (exp_q.size() > 0 && exp_q[0].w < n) begin
                    e = exp_q.pop_front();
                    check("missing_valid", 128'(e.ch), 128'(-1));
                end
            end
            for (int i = 0; i < NUM_CH; i++) packed_exp[32*i +: 32] = exp_recip[i];
            check("reciprocal_hold", 128'(reciprocal), packed_exp);
            check("busy", 128'(busy), 128'(n >= m_grant_edge && n < m_write_edge));
        end
    end

    task automatic drive(input logic [NUM_CH-1:0] req, input logic [NUM_CH*32-1:0] dur);
        @(negedge clk);
        ch_req      = req;
        ch_duration = dur;
        if (req != '0) last_req_edge = n + 1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive('0, ch_duration);
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_CH; i++) p |= m_pending[i];
        return p;
    endfunction

    task automatic wait_idle();
        int t;
        idle(3);
        t = 0;
        while ((exp_q.size() != 0 || any_pending()) && t < 600) begin
            idle(1);
            t++;
        end
        check("drain_pending", 128'(exp_q.size()), '0);
        idle(2);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        ch_req  = '0;
        idle(cycles);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int          e0;
        logic [31:0] d;
        logic [NUM_CH*32-1:0] durs;

        reset_n     = 1'b0;
        ch_req      = '0;
        ch_duration = '0;
        idle(3);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // All-channel collision straight after reset: ch0 first, 34-cycle spacing.
        obs_log.delete();
        drive(4'b1111, {32'd32768, 32'd3, 32'd2, 32'd1});
        e0 = last_req_edge;
        wait_idle();
        check("collision_count", 128'(obs_log.size()), 128'(4));
        if (obs_log.size() == 4) begin
            check("collision_ch0", 128'({obs_log[0].ch, obs_log[0].val}), 128'({32'd0, 32'd32768}));
            check("collision_ch1", 128'({obs_log[1].ch, obs_log[1].val}), 128'({32'd1, 32'd16384}));
            check("collision_ch2", 128'({obs_log[2].ch, obs_log[2].val}), 128'({32'd2, 32'd10922}));
            check("collision_ch3", 128'({obs_log[3].ch, obs_log[3].val}), 128'({32'd3, 32'd1}));
            for (int i = 0; i < 4; i++)
                check("collision_latency", 128'(obs_log[i].at_edge + 1 - e0), 128'(35 + 34 * i));
        end

        // Single request, nonzero duration.
        obs_log.delete();
        drive(4'b0001, {96'd0, 32'd1000});
        e0 = last_req_edge;
        wait_idle();
        check("single_count", 128'(obs_log.size()), 128'(1));
        if (obs_log.size() == 1) begin
            check("single_value", 128'({obs_log[0].ch, obs_log[0].val}), 128'({32'd0, 32'd32}));
            check("single_latency", 128'(obs_log[0].at_edge + 1 - e0), 128'(35));
        end

        // Divide by zero on ch2.
        obs_log.delete();
        drive(4'b0100, '0);
        e0 = last_req_edge;
        wait_idle();
        check("div0_count", 128'(obs_log.size()), 128'(1));
        if (obs_log.size() == 1) begin
            check("div0_value", 128'({obs_log[0].ch, obs_log[0].val}), 128'({32'd2, 32'hFFFF_FFFF}));
            check("div0_err_seen", 128'(obs_log[0].div0), 128'(1));
            check("div0_latency", 128'(obs_log[0].at_edge + 1 - e0), 128'(3));
        end

        // Re-request on ch0 while its division is in flight.
        obs_log.delete();
        drive(4'b0001, {96'd0, 32'd4});
        idle(10);
        drive(4'b0001, {96'd0, 32'd8});
        wait_idle();
        check("rereq_count", 128'(obs_log.size()), 128'(2));
        if (obs_log.size() == 2) begin
            check("rereq_first", 128'({obs_log[0].ch, obs_log[0].val}), 128'({32'd0, 32'd8192}));
            check("rereq_second", 128'({obs_log[1].ch, obs_log[1].val}), 128'({32'd0, 32'd4096}));
        end

        // Fairness: ch1 and ch3 request every cycle.
        obs_log.delete();
        for (int i = 0; i < 200; i++) begin
            durs = '0;
            durs[32*1 +: 32] = $urandom_range(1, 5000);
            durs[32*3 +: 32] = $urandom_range(1, 5000);
            drive(4'b1010, durs);
        end
        idle(1);
        wait_idle();
        check("fair_enough_grants", 128'(obs_log.size() >= 6), 128'(1));
        for (int i = 0; i < obs_log.size(); i++) begin
            check("fair_channel", 128'(obs_log[i].ch == 1 || obs_log[i].ch == 3), 128'(1));
            if (i > 0) check("fair_alternate", 128'(obs_log[i].ch != obs_log[i-1].ch), 128'(1));
        end

        // Reset during DIV aborts; a request on the release edge completes normally.
        obs_log.delete();
        drive(4'b0010, {64'd0, 32'd5, 32'd0});
        idle(11);
        do_reset(3);
        ch_req      = 4'b1000;
        ch_duration = {32'd7, 96'd0};
        last_req_edge = n + 1;
        e0 = last_req_edge;
        idle(1);
        wait_idle();
        check("reset_abort_count", 128'(obs_log.size()), 128'(1));
        if (obs_log.size() == 1) begin
            check("post_reset_value", 128'({obs_log[0].ch, obs_log[0].val}), 128'({32'd3, 32'd4681}));
            check("post_reset_latency", 128'(obs_log[0].at_edge + 1 - e0), 128'(35));
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic [NUM_CH-1:0] r;
            int                sel;
            r = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r[i] = ($urandom_range(0, 15) == 0);
                sel  = $urandom_range(0, 7);
                if (sel == 0)      d = '0;
                else if (sel < 4)  d = $urandom_range(1, 200);
                else if (sel < 6)  d = $urandom_range(1, 70000);
                else               d = $urandom;
                durs[32*i +: 32] = d;
            end
            drive(r, durs);
        end
        idle(1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
